// File: rtl/psum_acc_wb.sv
// ---------------------------------------------------------------------------
// psum_acc_wb - output partial-sum accumulator and write-back stage
//
// Takes one (address, partial sum) beat per cycle and read-modify-writes the
// output SRAM, accumulating across input channels. It forwards in-flight
// results around the SRAM read-after-write window, saturates to ACC_W, counts
// final writes to flag the end of a layer, and can bulk-zero the buffer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        beat handshake
//   in_addr, in_psum         output word address, signed partial sum
//   in_first, in_last        first channel (old value = 0), last channel
//   out_total                number of final writes that make up one layer
//   clr_start, clr_len       request zeroing of words 0..clr_len-1
//   mem_rd_en/addr/data      SRAM read port (data returned next cycle)
//   mem_wr_en/addr/data      SRAM write port (registered)
//   layer_done               one-cycle pulse with the layer's last write
//   busy                     clearing, or pipeline not empty
//
// Build option: define PSUM_RELU_EN to store max(sum,0) on final writes.
//
// state | meaning
// RUN   | accepting beats
// DRAIN | clear requested, waiting for S1 and write register to empty
// CLEAR | issuing one zero write per cycle
// ---------------------------------------------------------------------------
module psum_acc_wb #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_psum,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [ADDR_W-1:0] out_total,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [ACC_W-1:0]  mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ACC_W-1:0]  mem_wr_data,
    output logic              layer_done,
    output logic              busy
);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_nxt;

    logic              accept, clr_go, clr_exit, zero_wr, drained, clr_more;

    logic              s1_valid, s1_first, s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_psum;

    // Copy of the write issued last cycle: SRAM reads that collided with it
    // returned the old word.
    logic              dly_valid;
    logic [ADDR_W-1:0] dly_addr;
    logic [ACC_W-1:0]  dly_data;

    logic [ADDR_W-1:0] done_cnt, cnt_inc;
    logic [ADDR_W-1:0] clr_len_q, clr_idx;

    logic [ACC_W-1:0]  operand, sum_sat, store_val;
    logic [ACC_W:0]    sum_wide;

    assign drained  = !s1_valid && !mem_wr_en;
    assign clr_more = (clr_idx != clr_len_q);
    assign cnt_inc  = done_cnt + ADDR_W'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (clr_start && clr_len != '0) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = CLEAR;
            CLEAR:   if (!clr_more) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready    = !rst && (state == RUN) && !clr_start;
        accept      = in_ready && in_valid;
        mem_rd_en   = accept && !in_first;
        mem_rd_addr = accept ? in_addr : '0;
        busy        = !rst && ((state != RUN) || s1_valid || mem_wr_en);
        clr_go      = !rst && (state == RUN) && clr_start && (clr_len != '0);
        // The first zero write is registered in the last DRAIN cycle so it
        // lands in the first CLEAR cycle.
        zero_wr     = ((state == DRAIN) && drained) || ((state == CLEAR) && clr_more);
        clr_exit    = (state == CLEAR) && !clr_more;
    end

    // ---------------- S1 operand select and saturating add ----------------
    always_comb begin
        if (s1_first)
            operand = '0;
        else if (mem_wr_en && mem_wr_addr == s1_addr)
            operand = mem_wr_data;
        else if (dly_valid && dly_addr == s1_addr)
            operand = dly_data;
        else
            operand = mem_rd_data;

        sum_wide = {operand[ACC_W-1], operand}
                 + {{(ACC_W+1-DATA_W){s1_psum[DATA_W-1]}}, s1_psum};

        // Overflow when the two top bits disagree; the top bit is the true sign.
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sum_sat = sum_wide[ACC_W-1:0];

`ifdef PSUM_RELU_EN
        store_val = (s1_last && sum_sat[ACC_W-1]) ? '0 : sum_sat;
`else
        store_val = sum_sat;
`endif
    end

    // ---------------- pipeline, write register, counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_addr     <= '0;
            s1_psum     <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            layer_done  <= 1'b0;
            dly_valid   <= 1'b0;
            dly_addr    <= '0;
            dly_data    <= '0;
            done_cnt    <= '0;
            clr_len_q   <= '0;
            clr_idx     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_addr  <= in_addr;
                s1_psum  <= in_psum;
            end

            dly_valid <= mem_wr_en && !clr_exit;
            dly_addr  <= mem_wr_addr;
            dly_data  <= mem_wr_data;

            mem_wr_en  <= 1'b0;
            layer_done <= 1'b0;
            if (s1_valid) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= s1_addr;
                mem_wr_data <= store_val;
                if (s1_last) begin
                    if (out_total != '0 && cnt_inc == out_total) begin
                        layer_done <= 1'b1;
                        done_cnt   <= '0;
                    end else begin
                        done_cnt <= cnt_inc;
                    end
                end
            end else if (zero_wr) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= clr_idx;
                mem_wr_data <= '0;
            end

            if (clr_go) begin
                clr_len_q <= clr_len;
                clr_idx   <= '0;
            end else if (zero_wr) begin
                clr_idx <= clr_idx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_psum_acc_wb.sv
module tb_psum_acc_wb;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int ADW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [ADW-1:0] in_addr = '0;
    logic [DW-1:0]  in_psum = '0;
    logic           in_first = 1'b0;
    logic           in_last = 1'b0;
    logic [ADW-1:0] out_total = '0;
    logic           clr_start = 1'b0;
    logic [ADW-1:0] clr_len = '0;
    logic           mem_rd_en;
    logic [ADW-1:0] mem_rd_addr;
    logic [AW-1:0]  mem_rd_data = '0;
    logic           mem_wr_en;
    logic [ADW-1:0] mem_wr_addr;
    logic [AW-1:0]  mem_wr_data;
    logic           layer_done;
    logic           busy;

    always #5 clk = ~clk;

    psum_acc_wb #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_psum(in_psum), .in_first(in_first), .in_last(in_last),
        .out_total(out_total), .clr_start(clr_start), .clr_len(clr_len),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .layer_done(layer_done), .busy(busy)
    );

    typedef struct {
        int            due;
        int            addr;
        logic [AW-1:0] data;
        logic          done;
        logic [AW-1:0] old;
    } wr_t;

    wr_t           q[$];
    logic [AW-1:0] sram    [0:255];
    logic [AW-1:0] ref_mem [0:255];
    int errors = 0, checks = 0, cyc = 0, run_at = 0, cnt = 0;
    logic acc1 = 1'b0, acc2 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: signed add clamped to the ACC_W range.
    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] old, input int p);
        longint s;
        logic [63:0] u;
        s = longint'($signed(old)) + longint'(p);
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        u = s;
        return u[AW-1:0];
    endfunction

    task automatic preload(input int a, input logic [AW-1:0] v);
        sram[a]    = v;
        ref_mem[a] = v;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model, then emulate the SRAM edge.
    task automatic step(input int v, input int a, input int p, input int f, input int l,
                        input int cs, input int cl, input int r);
        logic exp_rdy, acc, exp_busy, run_now;
        logic rd_en_q, wr_en_q;
        logic [ADW-1:0] rd_a_q, wr_a_q;
        logic [AW-1:0] wr_d_q, oldv;
        wr_t e;
        @(negedge clk);
        cyc++;
        rst       = (r != 0);
        in_valid  = (v != 0);
        in_addr   = ADW'(a);
        in_psum   = DW'(p);
        in_first  = (f != 0);
        in_last   = (l != 0);
        clr_start = (cs != 0);
        clr_len   = ADW'(cl);
        #1;
        run_now  = (cyc >= run_at);
        exp_rdy  = (r == 0) && run_now && (cs == 0);
        acc      = (v != 0) && exp_rdy;
        exp_busy = (r == 0) && (!run_now || acc1 || acc2);

        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("mem_rd_en", 64'(mem_rd_en), 64'(acc && (f == 0)));
        if (acc && f == 0) chk("mem_rd_addr", 64'(mem_rd_addr), 64'(ADW'(a)));
        chk("busy", 64'(busy), 64'(exp_busy));
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("wr_en", 64'(mem_wr_en), 64'(1'b1));
            chk("wr_addr", 64'(mem_wr_addr), 64'(ADW'(e.addr)));
            chk("wr_data", 64'(mem_wr_data), 64'(e.data));
            chk("layer_done", 64'(layer_done), 64'(e.done));
        end else begin
            chk("wr_idle", 64'(mem_wr_en), 64'(1'b0));
            chk("done_idle", 64'(layer_done), 64'(1'b0));
        end

        if (r != 0) begin
            // In-flight beats are dropped: undo their effect on the model.
            while (q.size() > 0 && q[q.size()-1].due > cyc) begin
                e = q[q.size()-1];
                ref_mem[e.addr & 255] = e.old;
                void'(q.pop_back());
            end
            cnt = 0; acc1 = 1'b0; acc2 = 1'b0; run_at = cyc + 1;
        end else begin
            if (acc) begin
                e.addr = a;
                e.old  = ref_mem[a & 255];
                oldv   = (f != 0) ? '0 : e.old;
                e.data = sat_add(oldv, p);
`ifdef PSUM_RELU_EN
                if (l != 0 && e.data[AW-1]) e.data = '0;
`endif
                ref_mem[a & 255] = e.data;
                e.done = 1'b0;
                if (l != 0) begin
                    cnt++;
                    if (out_total != 0 && cnt == int'(out_total)) begin
                        e.done = 1'b1;
                        cnt = 0;
                    end
                end
                e.due = cyc + 2;
                q.push_back(e);
            end
            if (cs != 0 && run_now && cl != 0) begin
                for (int i = 0; i < cl; i++) begin
                    e.addr = i; e.data = '0; e.done = 1'b0;
                    e.old  = ref_mem[i & 255];
                    e.due  = cyc + 3 + i;
                    ref_mem[i & 255] = '0;
                    q.push_back(e);
                end
                run_at = cyc + 3 + cl;
            end
            acc2 = acc1; acc1 = acc;
        end

        rd_en_q = mem_rd_en; rd_a_q = mem_rd_addr;
        wr_en_q = mem_wr_en; wr_a_q = mem_wr_addr; wr_d_q = mem_wr_data;
        @(posedge clk);
        #1;
        if (rd_en_q) mem_rd_data = sram[rd_a_q[7:0]];
        if (wr_en_q) sram[wr_a_q[7:0]] = wr_d_q;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input int a, input int p, input int f, input int l);
        step(1, a, p, f, l, 0, 0, 0);
    endtask

    initial begin
        int v, a, p, f, l, cs, cl;
        for (int i = 0; i < 256; i++) begin
            sram[i] = '0; ref_mem[i] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        idle(2);

        // Three beats to one address, forwarded from the write register
        out_total = 16'd1;
        preload(5, 32'd999);
        beat(5, 3, 1, 0);
        beat(5, 4, 0, 0);
        beat(5, -2, 0, 1);
        idle(3);

        // 9, 10, 9: last beat forwarded from the delayed write copy
        preload(9, 32'd100);
        preload(10, 32'd50);
        beat(9, 1, 0, 0);
        beat(10, 1, 0, 0);
        beat(9, 1, 0, 0);
        idle(3);

        // Saturation both ways, and a negative final write (ReLU dependent)
        preload(2, 32'h7FFF_FFF6);
        preload(4, 32'h8000_0005);
        beat(2, 100, 0, 0);
        beat(4, -100, 0, 0);
        beat(3, -5, 1, 1);
        idle(3);

        // Layer done after four final writes
        out_total = 16'd4;
        idle(1);
        for (int i = 0; i < 4; i++) beat(i, 10 + i, 1, 1);
        idle(3);

        // Clear with two beats in flight; beat offered with clr_start is refused
        beat(20, 7, 1, 0);
        beat(21, 8, 1, 0);
        step(1, 22, 9, 1, 0, 1, 3, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 5, 0);
        idle(5);
        beat(1, 6, 0, 1);
        beat(21, 2, 0, 0);
        idle(3);

        // clr_len = 0: only the handshake is blocked for that cycle
        step(1, 7, 1, 1, 0, 1, 0, 0);
        beat(7, 2, 1, 0);
        idle(3);

        // Reset the cycle after an acceptance
        out_total = 16'd0;
        beat(30, 5, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst2_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst2_wr_data", 64'(mem_wr_data), 64'd0);
        idle(4);

        // Random traffic over a small address window (dense hazards)
        out_total = 16'd5;
        for (int i = 0; i < 16; i++) preload(i, AW'($urandom_range(0, 5000)));
        for (int n = 0; n < 500; n++) begin
            v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            a  = $urandom_range(0, 7);
            p  = int'($signed(16'($urandom)));
            f  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            l  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            cs = (($urandom_range(0, 40) == 0) && (acc1 || cyc + 1 < run_at)) ? 1 : 0;
            cl = $urandom_range(0, 4);
            step(v, a, p, f, l, cs, cl, 0);
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
